ccc_apb_cfg_master: RTL and testbench
=====================================

// Module: ccc_apb_cfg_master
// PURPOSE
//  APB initiator for the fabric CCC's dynamic-configuration port (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/BUSY).
//  Accepts single read/write commands from fabric logic, executes one APB transfer per command and waits for CCC BUSY low before SETUP.
//  After a reconfiguration write it can wait for PLL LOCK.
//  Sits between control logic and the CCC; CLK also drives the CCC PCLK at integration.
// PARAMETERS
//  ADDR_W        6     APB address width (CCC config space)
//  DATA_W        8     APB data width
//  LOCK_SYNC     2     synchronizer depth for async LOCK input (>=2)
//  LOCK_HOLD     16    consecutive synced-LOCK-high cycles required for success
//  LOCK_TIMEOUT  4096  max cycles in lock wait before error response
// PORTS
//  CLK        in   1       single clock; all logic rising-edge
//  RESET      in   1       reset: synchronous and active-high
//  CMD_VALID  in   1       command request
//  CMD_READY  out  1       high only in IDLE; command accepted when VALID&READY
//  CMD_WRITE  in   1       1=write, 0=read
//  CMD_RELOCK in   1       on a write: wait for LOCK afterwards (ignored on read)
//  CMD_ADDR   in   ADDR_W  register address
//  CMD_WDATA  in   DATA_W  write data
//  RSP_VALID  out  1       one-cycle completion pulse, no back-pressure
//  RSP_RDATA  out  DATA_W  read data (0 for writes), valid with RSP_VALID
//  RSP_ERR    out  1       lock timeout, valid with RSP_VALID
//  PSEL, PENABLE, PWRITE  out 1  APB controls to CCC
//  PADDR      out  ADDR_W  APB address
//  PWDATA     out  DATA_W  APB write data
//  PRDATA     in   DATA_W  APB read data from CCC
//  BUSY       in   1       CCC busy; no SETUP while high
//  LOCK       in   1       CCC PLL lock, asynchronous
//  LOCK_OK    out  1       synchronized LOCK, for status
// BEHAVIOUR
//  Reset values: all outputs 0, except CMD_READY=1 in the cycle after RESET deasserts. State=IDLE, counters 0, sync chain 0.
//  RESET asserted in any state aborts the transfer: APB outputs go 0 next edge and no RSP_VALID is issued.
//  FSM states: IDLE, WAIT_BUSY, SETUP, ACCESS, WAIT_LOCK, RESP.
//   IDLE: on accept, register WRITE/RELOCK/ADDR/WDATA. Go to SETUP if BUSY=0 that cycle, else WAIT_BUSY.
//   WAIT_BUSY: stay while BUSY=1 (no timeout), then SETUP.
//   SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven; one cycle, then ACCESS.
//   ACCESS: PSEL=1, PENABLE=1; exactly one cycle (the CCC has no PREADY).
//     On a read, PRDATA is captured at the end of ACCESS.
//     Next state is WAIT_LOCK if write&RELOCK, else RESP.
//   WAIT_LOCK: PSEL=PENABLE=0.
//     tmo_cnt increments every cycle.
//     hold_cnt increments while LOCK_OK=1 and clears to 0 when LOCK_OK=0.
//     When hold_cnt reaches LOCK_HOLD: RESP with ERR=0.
//     Else when tmo_cnt reaches LOCK_TIMEOUT-1: RESP with ERR=1.
//     If both occur in the same cycle, success wins.
//   RESP: RSP_VALID=1 for one cycle, then IDLE. CMD_READY stays 0 outside IDLE.
//  Latency with BUSY=0: accept at cycle 0, SETUP at 1, ACCESS at 2, RSP_VALID at 3.
//  PADDR/PWDATA/PWRITE hold stable from SETUP through ACCESS and are 0 otherwise.
//  Counter widths are $clog2(LOCK_TIMEOUT+1) and $clog2(LOCK_HOLD+1). No wrap: counters clear on entry to WAIT_LOCK.
//  LOCK_OK is the LOCK_SYNC-stage flop chain output; its latency is included in the hold count.
// STRUCTURE
//  Shared package ccc_cfg_pkg: FSM state enum; CCC address constants; default LOCK_HOLD/LOCK_TIMEOUT.
//  One sub-module: sync_bit (LOCK_SYNC-deep synchronizer, reset to 0). The rest is a single FSM plus counters.
// TESTING
//  1 Write ADDR=0x12 WDATA=0xA5, BUSY=0, RELOCK=0 -> SETUP cyc1, ACCESS cyc2, PADDR=0x12, PWDATA=0xA5, PWRITE=1; RSP_VALID cyc3, ERR=0.
//  2 Read ADDR=0x05, CCC model PRDATA=0x3C -> PWRITE=0; RSP_RDATA=0x3C at cyc3; APB outputs 0 at cyc3.
//  3 BUSY=1 for 5 cycles after accept -> PSEL stays 0 and CMD_READY stays 0; SETUP on the first cycle after BUSY falls.
//  4 Relock write (LOCK_HOLD=16): LOCK low 10 cycles after ACCESS, then high -> RSP_VALID after 16 LOCK_OK-high cycles, ERR=0.
//    A LOCK glitch low mid-count restarts the hold count.
//  5 Relock write, LOCK stuck low, LOCK_TIMEOUT=64 -> RSP_VALID with ERR=1 exactly 64 cycles after entering WAIT_LOCK; back to IDLE.
//  6 RESET asserted during ACCESS and during WAIT_LOCK -> next cycle all outputs 0, no RSP_VALID.
//    A new command after reset completes normally.

Source files
------------

// File: rtl/ccc_cfg_pkg.sv
// ccc_cfg_pkg
//   Shared definitions for the CCC dynamic-configuration APB initiator:
//   FSM state encoding, default lock-wait timing and a few well-known
//   CCC configuration register addresses.
//   No ports (package).
package ccc_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT_LOCK,
    ST_RESP
  } cfg_state_t;

  localparam int LOCK_HOLD_DEF    = 16;
  localparam int LOCK_TIMEOUT_DEF = 4096;

  // CCC configuration space landmarks
  localparam logic [5:0] CCC_ADDR_PLL_CTRL  = 6'h00;
  localparam logic [5:0] CCC_ADDR_PLL_DIV   = 6'h05;
  localparam logic [5:0] CCC_ADDR_OUT_DIV   = 6'h12;
  localparam logic [5:0] CCC_ADDR_PHASE     = 6'h20;

endpackage

// File: rtl/ccc_apb_cfg_master_sync_bit.sv
// sync_bit
//   DEPTH-stage flop synchronizer for a single asynchronous bit.
//   Chain clears to 0 on a synchronous reset.
// Ports:
//   clk  in  sampling clock
//   rst  in  synchronous active-high reset
//   d    in  asynchronous input
//   q    out synchronized output (DEPTH cycles of latency)
module sync_bit #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= {chain_q[DEPTH-2:0], d};
  end

  assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/ccc_apb_cfg_master.sv
// ccc_apb_cfg_master
//   APB initiator for the CCC dynamic-configuration port. Runs one APB
//   transfer per accepted command, holds off SETUP while the CCC reports
//   BUSY, and after a relock write waits for a stable PLL LOCK.
// Ports:
//   CLK, RESET                 clock / synchronous active-high reset
//   CMD_VALID/READY            command handshake (READY only in IDLE)
//   CMD_WRITE/RELOCK/ADDR/WDATA command fields
//   RSP_VALID/RDATA/ERR        one-cycle completion (ERR = lock timeout)
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA  APB to the CCC
//   BUSY                       CCC busy, blocks SETUP
//   LOCK                       asynchronous PLL lock
//   LOCK_OK                    synchronized LOCK
//
// state      | meaning
// -----------+---------------------------------------------------
// IDLE       | ready for a command
// WAIT_BUSY  | command latched, waiting for BUSY low
// SETUP      | APB setup phase (PSEL=1, PENABLE=0)
// ACCESS     | APB access phase, single cycle (no PREADY)
// WAIT_LOCK  | post-write lock qualification with timeout
// RESP       | one-cycle response pulse
module ccc_apb_cfg_master
  import ccc_cfg_pkg::*;
#(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 8,
  parameter int LOCK_SYNC    = 2,
  parameter int LOCK_HOLD    = LOCK_HOLD_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic              CMD_RELOCK,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              BUSY,
  input  logic              LOCK,
  output logic              LOCK_OK
);

  localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(LOCK_HOLD);

  cfg_state_t state_q, state_d;

  logic              accept;
  logic              hold_met;
  logic              tmo_met;
  logic              write_q;
  logic              relock_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  sync_bit #(.DEPTH(LOCK_SYNC)) u_lock_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (LOCK),
    .q   (LOCK_OK)
  );

  assign accept   = CMD_VALID & CMD_READY;
  assign hold_met = (hold_cnt == HOLD_DONE);
  assign tmo_met  = (tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (accept) state_d = BUSY ? ST_WAIT_BUSY : ST_SETUP;
      ST_WAIT_BUSY: if (!BUSY) state_d = ST_SETUP;
      ST_SETUP:     state_d = ST_ACCESS;
      ST_ACCESS:    state_d = (write_q && relock_q) ? ST_WAIT_LOCK : ST_RESP;
      // success is checked first so a simultaneous timeout still reports OK
      ST_WAIT_LOCK: if (hold_met || tmo_met) state_d = ST_RESP;
      ST_RESP:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    CMD_READY = 1'b0;
    RSP_VALID = 1'b0;
    RSP_RDATA = '0;
    RSP_ERR   = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    PWRITE    = 1'b0;
    PADDR     = '0;
    PWDATA    = '0;
    case (state_q)
      // gated so READY reads 0 while reset is still held
      ST_IDLE: CMD_READY = ~RESET;
      ST_SETUP, ST_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (state_q == ST_ACCESS);
        PWRITE  = write_q;
        PADDR   = addr_q;
        PWDATA  = wdata_q;
      end
      ST_RESP: begin
        RSP_VALID = 1'b1;
        RSP_RDATA = rdata_q;
        RSP_ERR   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      write_q  <= 1'b0;
      relock_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      if (accept) begin
        write_q  <= CMD_WRITE;
        relock_q <= CMD_WRITE & CMD_RELOCK;
        addr_q   <= CMD_ADDR;
        wdata_q  <= CMD_WDATA;
      end
      if (state_q == ST_ACCESS) begin
        rdata_q  <= write_q ? '0 : PRDATA;
        err_q    <= 1'b0;
        tmo_cnt  <= '0;
        hold_cnt <= '0;
      end
      if (state_q == ST_WAIT_LOCK) begin
        tmo_cnt  <= tmo_cnt + TMO_W'(1);
        hold_cnt <= LOCK_OK ? hold_cnt + HOLD_W'(1) : '0;
        err_q    <= tmo_met & ~hold_met;
      end
    end
  end

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
module tb_ccc_apb_cfg_master;

  localparam int TB_HOLD    = 16;
  localparam int TB_TIMEOUT = 64;
  localparam int HIST       = 4096;

  logic       clk;
  logic       RESET;
  logic       CMD_VALID, CMD_READY, CMD_WRITE, CMD_RELOCK;
  logic [5:0] CMD_ADDR;
  logic [7:0] CMD_WDATA;
  logic       RSP_VALID, RSP_ERR;
  logic [7:0] RSP_RDATA;
  logic       PSEL, PENABLE, PWRITE;
  logic [5:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       BUSY, LOCK, LOCK_OK;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  ccc_apb_cfg_master #(
    .ADDR_W(6), .DATA_W(8), .LOCK_SYNC(2),
    .LOCK_HOLD(TB_HOLD), .LOCK_TIMEOUT(TB_TIMEOUT)
  ) dut (
    .CLK(clk), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_RELOCK(CMD_RELOCK), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .BUSY(BUSY), .LOCK(LOCK), .LOCK_OK(LOCK_OK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // simple CCC register file: APB writes land on the access phase
  logic [7:0] ccc_mem [0:63];
  always @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < 64; i++) ccc_mem[i] <= 8'h00;
      ccc_mem[5] <= 8'h3C;
    end else if (PSEL && PENABLE && PWRITE) begin
      ccc_mem[PADDR] <= PWDATA;
    end
  end
  assign PRDATA = ccc_mem[PADDR];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-timeline model ----------------
  bit         m_active = 1'b0;
  bit         m_rst_prev = 1'b1;
  bit         m_write, m_relock, m_err;
  logic [5:0] m_addr;
  logic [7:0] m_wdata, m_rdata;
  int         t_setup = -1, t_wait = -1, t_resp = -1;
  bit         ls1 = 1'b0, ls2 = 1'b0;
  bit         lok_hist [0:HIST-1];

  always @(negedge clk) begin
    int n;
    bit e_ready, e_psel, e_pen, e_rv, hold_ok;
    n = cyc;
    if (m_rst_prev) m_active = 1'b0;
    if (m_active && t_resp >= 0 && n > t_resp) m_active = 1'b0;

    e_ready = !m_active && !RESET;
    e_psel  = m_active && t_setup >= 0 && (n == t_setup || n == t_setup + 1);
    e_pen   = m_active && t_setup >= 0 && n == t_setup + 1;
    e_rv    = m_active && t_resp >= 0 && n == t_resp;

    chk("cmd_ready", int'(CMD_READY), int'(e_ready));
    chk("psel", int'(PSEL), int'(e_psel));
    chk("penable", int'(PENABLE), int'(e_pen));
    chk("pwrite", int'(PWRITE), int'(e_psel && m_write));
    chk("paddr", int'(PADDR), e_psel ? int'(m_addr) : 0);
    chk("pwdata", int'(PWDATA), e_psel ? int'(m_wdata) : 0);
    chk("rsp_valid", int'(RSP_VALID), int'(e_rv));
    chk("lock_ok", int'(LOCK_OK), int'(ls2));
    if (e_rv) begin
      chk("rsp_rdata", int'(RSP_RDATA), int'(m_rdata));
      chk("rsp_err", int'(RSP_ERR), int'(m_err));
    end

    if (n < HIST) lok_hist[n] = ls2;

    if (e_ready && CMD_VALID) begin
      m_active = 1'b1;
      t_setup  = -1; t_wait = -1; t_resp = -1;
      m_write  = CMD_WRITE;
      m_relock = CMD_WRITE && CMD_RELOCK;
      m_addr   = CMD_ADDR;
      m_wdata  = CMD_WDATA;
      m_rdata  = 8'h00;
      m_err    = 1'b0;
    end
    if (m_active && t_setup < 0 && !BUSY) t_setup = n + 1;
    if (m_active && t_setup >= 0 && n == t_setup + 1) begin
      if (!m_write) begin m_rdata = PRDATA; t_resp = n + 1; end
      else if (!m_relock) t_resp = n + 1;
      else t_wait = n + 1;
    end
    if (m_active && m_relock && t_wait >= 0 && t_resp < 0 && n >= t_wait) begin
      // success: the last TB_HOLD cycles of the wait all saw LOCK_OK high
      hold_ok = (n - TB_HOLD >= t_wait);
      for (int j = n - TB_HOLD; j < n; j++)
        if (j >= 0 && j < HIST && !lok_hist[j]) hold_ok = 1'b0;
      if (hold_ok || (n - t_wait == TB_TIMEOUT - 1)) begin
        t_resp = n + 1;
        m_err  = !hold_ok;
      end
    end

    m_rst_prev = RESET;
    ls2 = RESET ? 1'b0 : ls1;
    ls1 = RESET ? 1'b0 : LOCK;
  end

  // ---------------- directed stimulus ----------------
  task automatic run_cmd(input bit w, input bit rl, input logic [5:0] ad, input logic [7:0] wd,
                         input int busy_len, input int lock_on, input int glitch,
                         input int rst_at, input int max_wait,
                         output int r, output int setup_off, output logic [7:0] rd,
                         output logic er, output bit ready_in_txn, output bit post_rst_nz);
    r = -1; setup_off = -1; rd = 8'h00; er = 1'b0; ready_in_txn = 1'b0; post_rst_nz = 1'b0;
    for (int off = 0; off <= max_wait; off++) begin
      if (off > 0) begin @(posedge clk); #1; end
      CMD_VALID  = (off == 0);
      CMD_WRITE  = w;
      CMD_RELOCK = rl;
      CMD_ADDR   = ad;
      CMD_WDATA  = wd;
      BUSY  = (off < busy_len);
      LOCK  = (lock_on >= 0) && (off >= lock_on) && (off != glitch);
      RESET = (off == rst_at);
      @(negedge clk);
      if (PSEL && setup_off < 0) setup_off = off;
      if (off > 0 && r < 0 && rst_at < 0 && CMD_READY) ready_in_txn = 1'b1;
      if (RSP_VALID && r < 0) begin r = off; rd = RSP_RDATA; er = RSP_ERR; end
      if (rst_at >= 0 && off == rst_at + 1)
        post_rst_nz = PSEL | PENABLE | PWRITE | (|PADDR) | (|PWDATA) | RSP_VALID |
                      RSP_ERR | (|RSP_RDATA) | LOCK_OK;
      if (r >= 0 && off > r) break;
    end
    @(posedge clk); #1;
    CMD_VALID = 1'b0;
    BUSY      = 1'b0;
    RESET     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, s;
    logic [7:0] rd;
    logic er;
    bit rdy, pz;

    RESET = 1'b1; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_RELOCK = 1'b0;
    CMD_ADDR = 6'h00; CMD_WDATA = 8'h00; BUSY = 1'b0; LOCK = 1'b0;
    repeat (3) @(posedge clk);
    #1 RESET = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(CMD_READY), 1);
    chk("psel_after_reset", int'(PSEL), 0);
    chk("rsp_after_reset", int'(RSP_VALID), 0);
    @(posedge clk); #1;

    // 1: plain write
    run_cmd(1, 0, 6'h12, 8'hA5, 0, -1, -1, -1, 10, r, s, rd, er, rdy, pz);
    chk("t1_setup_off", s, 1);
    chk("t1_rsp_off", r, 3);
    chk("t1_err", int'(er), 0);
    chk("t1_rdata", int'(rd), 0);
    chk("t1_ready_in_txn", int'(rdy), 0);

    // 2: read of preset register
    run_cmd(0, 0, 6'h05, 8'h00, 0, -1, -1, -1, 10, r, s, rd, er, rdy, pz);
    chk("t2_rsp_off", r, 3);
    chk("t2_rdata", int'(rd), 'h3C);

    // read back the register written in test 1
    run_cmd(0, 0, 6'h12, 8'h00, 0, -1, -1, -1, 10, r, s, rd, er, rdy, pz);
    chk("t2b_rdata", int'(rd), 'hA5);

    // 3: BUSY held for 5 cycles from accept
    run_cmd(1, 0, 6'h00, 8'h11, 5, -1, -1, -1, 20, r, s, rd, er, rdy, pz);
    chk("t3_setup_off", s, 6);
    chk("t3_rsp_off", r, 8);
    chk("t3_ready_in_txn", int'(rdy), 0);

    // 4: relock write, LOCK rises 10 cycles after ACCESS
    run_cmd(1, 1, 6'h00, 8'h22, 0, 13, -1, -1, 80, r, s, rd, er, rdy, pz);
    chk("t4_rsp_off", r, 32);
    chk("t4_err", int'(er), 0);

    // 4b: one-cycle LOCK glitch restarts the hold count
    run_cmd(1, 1, 6'h00, 8'h23, 0, 13, 21, -1, 80, r, s, rd, er, rdy, pz);
    chk("t4b_rsp_off", r, 41);
    chk("t4b_err", int'(er), 0);

    // 5: LOCK stuck low -> timeout
    run_cmd(1, 1, 6'h00, 8'h24, 0, -1, -1, -1, 90, r, s, rd, er, rdy, pz);
    chk("t5_rsp_off", r, 67);
    chk("t5_err", int'(er), 1);
    chk("t5_ready_in_txn", int'(rdy), 0);

    // 6a: reset during ACCESS
    run_cmd(1, 0, 6'h12, 8'h77, 0, -1, -1, 2, 8, r, s, rd, er, rdy, pz);
    chk("t6a_no_rsp", r, -1);
    chk("t6a_outputs_zero", int'(pz), 0);

    // 6b: reset during WAIT_LOCK with LOCK_OK already high
    run_cmd(1, 1, 6'h00, 8'h33, 0, 5, -1, 10, 20, r, s, rd, er, rdy, pz);
    chk("t6b_no_rsp", r, -1);
    chk("t6b_outputs_zero", int'(pz), 0);

    // 6c: normal traffic after reset
    run_cmd(1, 0, 6'h20, 8'h5A, 0, -1, -1, -1, 10, r, s, rd, er, rdy, pz);
    chk("t6c_rsp_off", r, 3);
    run_cmd(0, 0, 6'h20, 8'h00, 0, -1, -1, -1, 10, r, s, rd, er, rdy, pz);
    chk("t6c_rsp_off_rd", r, 3);
    chk("t6c_rdata", int'(rd), 'h5A);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
